// File: rtl/and3_result_fifo_if.sv
// Capture/drain bus of the AND3 result FIFO: strobed source side, valid/ready sink side,
// plus status. The master drives the inputs; the FIFO attaches to the slave view.
interface and3_result_fifo_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic [5:0]               in_data;
    logic                     in_strobe;
    logic                     clr;
    logic                     out_valid;
    logic                     out_ready;
    logic [5:0]               out_data;
    logic [2:0]               out_ones;
    logic [$clog2(DEPTH):0]   level;
    logic [CNT_W-1:0]         accept_cnt;
    logic                     overflow;

    modport master (
        output in_data, in_strobe, clr, out_ready,
        input  out_valid, out_data, out_ones, level, accept_cnt, overflow
    );

    modport slave (
        input  in_data, in_strobe, clr, out_ready,
        output out_valid, out_data, out_ones, level, accept_cnt, overflow
    );
endinterface

// File: rtl/and3_result_fifo.sv
// Strobe-sampled FIFO for the 6-bit simple_and_3 result. Drops on full with a sticky flag,
// counts accepted entries (saturating) and annotates the head entry with its popcount.
module and3_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    and3_result_fifo_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [5:0]       mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [LW-1:0]    level_q, level_nxt;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             full, push, drop, pop;

    // Fullness uses the pre-edge level, so a pop never frees room for a same-cycle strobe.
    assign full = (level_q == LW'(DEPTH));
    assign push = bus.in_strobe && !full;
    assign drop = bus.in_strobe && full;
    assign pop  = valid_q && bus.out_ready;

    always_comb begin
        level_nxt = level_q;
        if (push && !pop)      level_nxt = level_q + 1'b1;
        else if (pop && !push) level_nxt = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp      <= '0;
            rp      <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wp] <= bus.in_data;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            level_q <= level_nxt;
            valid_q <= (level_nxt != '0);
        end
    end

    // clr loses to a same-cycle push (count restarts at 1) and to a same-cycle drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (bus.clr)                  cnt_q <= push ? CNT_W'(1) : '0;
            else if (push && cnt_q != '1) cnt_q <= cnt_q + 1'b1;

            if (drop)         ovf_q <= 1'b1;
            else if (bus.clr) ovf_q <= 1'b0;
        end
    end

    always_comb begin
        bus.out_ones = '0;
        for (int i = 0; i < 6; i++) bus.out_ones = bus.out_ones + 3'(bus.out_data[i]);
    end

    assign bus.out_data   = mem[rp];
    assign bus.out_valid  = valid_q;
    assign bus.level      = level_q;
    assign bus.accept_cnt = cnt_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_and3_result_fifo.sv
// Directed bench: main instance (DEPTH=4, CNT_W=16) plus a CNT_W=4 instance for saturation.
module tb_and3_result_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    and3_result_fifo_if #(.DEPTH(4), .CNT_W(16)) a ();
    and3_result_fifo_if #(.DEPTH(4), .CNT_W(4))  b ();

    and3_result_fifo #(.DEPTH(4), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    and3_result_fifo #(.DEPTH(4), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input int d, input int ones);
        chk({tag, " valid"}, int'(a.out_valid), 1);
        chk({tag, " data"}, int'(a.out_data), d);
        chk({tag, " ones"}, int'(a.out_ones), ones);
    endtask

    initial begin
        logic [5:0] fill [4];
        logic [5:0] v;
        fill = '{6'h01, 6'h03, 6'h07, 6'h0F};
        a.in_data = '0; a.in_strobe = 0; a.clr = 0; a.out_ready = 0;
        b.in_data = '0; b.in_strobe = 0; b.clr = 0; b.out_ready = 0;

        #12;
        chk("rst valid", int'(a.out_valid), 0);
        chk("rst level", int'(a.level), 0);
        chk("rst data", int'(a.out_data), 0);
        chk("rst ones", int'(a.out_ones), 0);
        chk("rst cnt", int'(a.accept_cnt), 0);
        chk("rst ovf", int'(a.overflow), 0);
        tick();
        rst_n = 1;
        tick();

        // single strobe, one-cycle latency
        a.in_data = 6'b101101; a.in_strobe = 1;
        tick();
        a.in_strobe = 0;
        chk_head("single", 6'h2D, 4);
        chk("single level", int'(a.level), 1);
        chk("single cnt", int'(a.accept_cnt), 1);
        a.out_ready = 1; tick(); a.out_ready = 0;
        chk("single drained", int'(a.out_valid), 0);
        a.clr = 1; tick(); a.clr = 0;
        chk("clr cnt", int'(a.accept_cnt), 0);

        // fill and drop on full
        for (int i = 0; i < 4; i++) begin
            a.in_data = fill[i]; a.in_strobe = 1; tick();
        end
        chk("fill ovf pre", int'(a.overflow), 0);
        a.in_data = 6'h3F; tick(); a.in_strobe = 0;
        chk("fill level", int'(a.level), 4);
        chk("fill ovf", int'(a.overflow), 1);
        chk("fill cnt", int'(a.accept_cnt), 4);
        a.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk_head("drain", int'(fill[i]), i + 1);
            tick();
        end
        a.out_ready = 0;
        chk("drain empty", int'(a.out_valid), 0);

        // full with simultaneous strobe and pop
        a.clr = 1; tick(); a.clr = 0;
        chk("clr ovf", int'(a.overflow), 0);
        a.in_strobe = 1;
        a.in_data = 6'h11; tick();
        a.in_data = 6'h22; tick();
        a.in_data = 6'h33; tick();
        a.in_data = 6'h04; tick();
        a.in_data = 6'h3F; a.out_ready = 1; tick();
        chk("fullpop level", int'(a.level), 3);
        chk("fullpop ovf", int'(a.overflow), 1);
        a.in_data = 6'h2A; a.out_ready = 0; tick();
        a.in_strobe = 0;
        chk("fullpop refill", int'(a.level), 4);
        a.out_ready = 1;
        chk_head("fp0", 6'h22, 2); tick();
        chk_head("fp1", 6'h33, 4); tick();
        chk_head("fp2", 6'h04, 1); tick();
        chk_head("fp3", 6'h2A, 3); tick();
        chk("fp empty", int'(a.out_valid), 0);

        // streaming: output equals input one cycle later
        a.clr = 1; tick(); a.clr = 0;
        a.in_strobe = 1;
        for (int i = 0; i < 20; i++) begin
            v = 6'(i * 7 + 5);
            a.in_data = v;
            tick();
            chk("stream level", int'(a.level), 1);
            chk("stream data", int'(a.out_data), int'(v));
        end
        a.in_strobe = 0; tick();
        chk("stream empty", int'(a.level), 0);
        chk("stream cnt", int'(a.accept_cnt), 20);
        chk("stream ovf", int'(a.overflow), 0);

        // wrap and saturation on the narrow counter
        b.in_strobe = 1; b.out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            v = 6'(63 - i * 3);
            b.in_data = v;
            tick();
            chk("wrap data", int'(b.out_data), int'(v));
        end
        chk("sat cnt", int'(b.accept_cnt), 15);
        b.clr = 1; b.in_data = 6'h01; tick();
        b.clr = 0; b.in_strobe = 0;
        chk("clr+push cnt", int'(b.accept_cnt), 1);
        chk("wrap ovf", int'(b.overflow), 0);

        // asynchronous reset mid-stream, with overflow set
        a.out_ready = 0; a.in_strobe = 1;
        for (int i = 0; i < 5; i++) begin
            a.in_data = 6'(6'h15 + i); tick();
        end
        a.in_strobe = 0; a.out_ready = 1; tick(); a.out_ready = 0;
        chk("pre-rst level", int'(a.level), 3);
        chk("pre-rst ovf", int'(a.overflow), 1);
        #2 rst_n = 0;
        #1;
        chk("arst valid", int'(a.out_valid), 0);
        chk("arst level", int'(a.level), 0);
        chk("arst ovf", int'(a.overflow), 0);
        chk("arst data", int'(a.out_data), 0);
        #1 rst_n = 1;
        tick();
        a.in_data = 6'h09; a.in_strobe = 1; tick(); a.in_strobe = 0;
        chk_head("post-rst", 6'h09, 2);
        chk("post-rst level", int'(a.level), 1);
        chk("post-rst cnt", int'(a.accept_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
